// File: rtl/jogador_pkg.sv
// Shared definitions for the automatic memory-game player: state codes,
// the fixed 16-entry jogada sequence and the error-injection rotate.
package jogador_pkg;

  // State codes are visible on db_estado, so the encoding is fixed.
  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    PRESSIONA   = 4'd2,
    SOLTA       = 4'd3,
    PROXIMA     = 4'd4,
    FIM_GANHOU  = 4'd5,
    FIM_PERDEU  = 4'd6,
    FIM_TIMEOUT = 4'd7
  } estado_t;

  // Jogada sequence; must match the game datapath's memory image.
  localparam logic [3:0] JOGADA_0  = 4'b0001;
  localparam logic [3:0] JOGADA_1  = 4'b0010;
  localparam logic [3:0] JOGADA_2  = 4'b0100;
  localparam logic [3:0] JOGADA_3  = 4'b1000;
  localparam logic [3:0] JOGADA_4  = 4'b0100;
  localparam logic [3:0] JOGADA_5  = 4'b0010;
  localparam logic [3:0] JOGADA_6  = 4'b0001;
  localparam logic [3:0] JOGADA_7  = 4'b0001;
  localparam logic [3:0] JOGADA_8  = 4'b0010;
  localparam logic [3:0] JOGADA_9  = 4'b0010;
  localparam logic [3:0] JOGADA_10 = 4'b0100;
  localparam logic [3:0] JOGADA_11 = 4'b0100;
  localparam logic [3:0] JOGADA_12 = 4'b1000;
  localparam logic [3:0] JOGADA_13 = 4'b1000;
  localparam logic [3:0] JOGADA_14 = 4'b0001;
  localparam logic [3:0] JOGADA_15 = 4'b0100;

  // Rotate left by one: keeps the press one-hot but always wrong.
  function automatic logic [3:0] rotl4(input logic [3:0] b);
    return {b[2:0], b[3]};
  endfunction

endpackage

// File: rtl/rom_jogadas_16x4.sv
// Combinational 16x4 sequence ROM holding the reference jogada list.
module rom_jogadas_16x4
  import jogador_pkg::*;
(
  input  logic [3:0] addr,
  output logic [3:0] dado
);

  // Pure table lookup, no state.
  always_comb begin
    dado = JOGADA_0;
    case (addr)
      4'd0:  dado = JOGADA_0;
      4'd1:  dado = JOGADA_1;
      4'd2:  dado = JOGADA_2;
      4'd3:  dado = JOGADA_3;
      4'd4:  dado = JOGADA_4;
      4'd5:  dado = JOGADA_5;
      4'd6:  dado = JOGADA_6;
      4'd7:  dado = JOGADA_7;
      4'd8:  dado = JOGADA_8;
      4'd9:  dado = JOGADA_9;
      4'd10: dado = JOGADA_10;
      4'd11: dado = JOGADA_11;
      4'd12: dado = JOGADA_12;
      4'd13: dado = JOGADA_13;
      4'd14: dado = JOGADA_14;
      4'd15: dado = JOGADA_15;
      default: dado = JOGADA_0;
    endcase
  end

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: replays the jogada sequence round by round on botoes,
// stopping on the game's ganhou/perdeu flags or after the 16th round.
module jogador_automatico
  import jogador_pkg::*;
#(
  parameter int PRESS_CYCLES     = 3,
  parameter int GAP_CYCLES       = 2,
  parameter int ROUND_GAP_CYCLES = 5,
  parameter int ERRO_RODADA      = 0,
  parameter int TIMER_W          = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       ganhou,
  input  logic       perdeu,
  output logic [3:0] botoes,
  output logic       ativo,
  output logic       fim,
  output logic       venceu,
  output logic [3:0] db_estado,
  output logic [3:0] db_rodada,
  output logic [3:0] db_jogada
);

  localparam logic [TIMER_W-1:0] T_PRESS = TIMER_W'(PRESS_CYCLES);
  localparam logic [TIMER_W-1:0] T_GAP   = TIMER_W'(GAP_CYCLES);
  localparam logic [TIMER_W-1:0] T_RGAP  = TIMER_W'(ROUND_GAP_CYCLES);
  localparam logic [TIMER_W-1:0] T_ONE   = TIMER_W'(1);

  // Round index (rodada-1) whose last play gets corrupted, if enabled.
  localparam bit       ERR_EN    = (ERRO_RODADA >= 1) && (ERRO_RODADA <= 16);
  localparam int       ERR_IDX_I = ERR_EN ? (ERRO_RODADA - 1) : 0;
  localparam logic [3:0] ERR_IDX = ERR_IDX_I[3:0];

  estado_t            state_q, state_d;
  logic [3:0]         rodada_q, rodada_d;
  logic [3:0]         jogada_q, jogada_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         botoes_q, botoes_d;
  logic [3:0]         rom_dado;
  logic               erro;

  // ROM is addressed with the next jogada so botoes can be registered
  // in the same edge that enters PRESSIONA.
  rom_jogadas_16x4 u_rom (
    .addr (jogada_d),
    .dado (rom_dado)
  );

  // State, counter and timer registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= INICIAL;
      rodada_q <= '0;
      jogada_q <= '0;
      timer_q  <= '0;
      botoes_q <= '0;
    end else begin
      state_q  <= state_d;
      rodada_q <= rodada_d;
      jogada_q <= jogada_d;
      timer_q  <= timer_d;
      botoes_q <= botoes_d;
    end
  end

  // Next-state logic: timer loads on state entry and the state leaves on
  // the cycle it reads 1, giving exact durations.
  always_comb begin
    state_d  = state_q;
    rodada_d = rodada_q;
    jogada_d = jogada_q;
    timer_d  = timer_q;

    case (state_q)
      INICIAL: begin
        if (iniciar) begin
          state_d  = PREPARA;
          rodada_d = '0;
          jogada_d = '0;
          timer_d  = '0;
        end
      end
      PREPARA: begin
        state_d = PRESSIONA;
        timer_d = T_PRESS;
      end
      PRESSIONA: begin
        if (timer_q <= T_ONE) begin
          state_d = SOLTA;
          timer_d = (jogada_q == rodada_q) ? T_RGAP : T_GAP;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      SOLTA: begin
        if (timer_q <= T_ONE) begin
          state_d = PROXIMA;
          timer_d = '0;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      PROXIMA: begin
        if (jogada_q < rodada_q) begin
          jogada_d = jogada_q + 4'd1;
          state_d  = PRESSIONA;
          timer_d  = T_PRESS;
        end else if (rodada_q < 4'd15) begin
          rodada_d = rodada_q + 4'd1;
          jogada_d = '0;
          state_d  = PRESSIONA;
          timer_d  = T_PRESS;
        end else begin
          state_d = FIM_TIMEOUT;
          timer_d = '0;
        end
      end
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
        if (iniciar) begin
          state_d  = PREPARA;
          rodada_d = '0;
          jogada_d = '0;
          timer_d  = '0;
        end
      end
      default: begin
        state_d = INICIAL;
        timer_d = '0;
      end
    endcase

    // Game verdict overrides sequencing while a run is playing; a loss
    // wins over a simultaneous win. Counters freeze for debug visibility.
    if (state_q inside {PRESSIONA, SOLTA, PROXIMA}) begin
      if (perdeu) begin
        state_d  = FIM_PERDEU;
        rodada_d = rodada_q;
        jogada_d = jogada_q;
        timer_d  = '0;
      end else if (ganhou) begin
        state_d  = FIM_GANHOU;
        rodada_d = rodada_q;
        jogada_d = jogada_q;
        timer_d  = '0;
      end
    end
  end

  // Button value registered alongside the state it belongs to.
  always_comb begin
    erro     = ERR_EN && (rodada_d == ERR_IDX) && (jogada_d == rodada_d);
    botoes_d = '0;
    if (state_d == PRESSIONA)
      botoes_d = erro ? rotl4(rom_dado) : rom_dado;
  end

  assign botoes    = botoes_q;
  assign ativo     = state_q inside {PREPARA, PRESSIONA, SOLTA, PROXIMA};
  assign fim       = state_q inside {FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT};
  assign venceu    = (state_q == FIM_GANHOU);
  assign db_estado = state_q;
  assign db_rodada = rodada_q;
  assign db_jogada = jogada_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico: default instance plus an
// instance with error injection on round 3.
module tb_jogador_automatico;

  localparam int PRESS = 3;
  localparam int GAP   = 2;
  localparam int RGAP  = 5;

  logic clock = 0;
  logic reset = 1;
  logic iniciar = 0, ganhou = 0, perdeu = 0;
  logic iniciar_e = 0, ganhou_e = 0, perdeu_e = 0;
  logic [3:0] botoes, db_estado, db_rodada, db_jogada;
  logic ativo, fim, venceu;
  logic [3:0] botoes_e, db_estado_e, db_rodada_e, db_jogada_e;
  logic ativo_e, fim_e, venceu_e;

  logic [3:0] rom_ref [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0100, 4'b0010, 4'b0001, 4'b0001,
                               4'b0010, 4'b0010, 4'b0100, 4'b0100,
                               4'b1000, 4'b1000, 4'b0001, 4'b0100};

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  jogador_automatico dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .ganhou(ganhou),
    .perdeu(perdeu), .botoes(botoes), .ativo(ativo), .fim(fim),
    .venceu(venceu), .db_estado(db_estado), .db_rodada(db_rodada),
    .db_jogada(db_jogada)
  );

  jogador_automatico #(.ERRO_RODADA(3)) dut_e (
    .clock(clock), .reset(reset), .iniciar(iniciar_e), .ganhou(ganhou_e),
    .perdeu(perdeu_e), .botoes(botoes_e), .ativo(ativo_e), .fim(fim_e),
    .venceu(venceu_e), .db_estado(db_estado_e), .db_rodada(db_rodada_e),
    .db_jogada(db_jogada_e)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic start_run();
    iniciar = 1;
    step();
    iniciar = 0;
    step();
  endtask

  // Advance until the selected DUT shows the given state/round/play.
  task automatic wait_for(input bit use_e, input logic [3:0] est,
                          input logic [3:0] rod, input logic [3:0] jog,
                          input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (use_e ? (db_estado_e == est && db_rodada_e == rod && db_jogada_e == jog)
                : (db_estado == est && db_rodada == rod && db_jogada == jog)) begin
        ok = 1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (botoes !== 4'b0000) begin n_fail++; $display("FAIL reset_botoes got %b want 0000", botoes); end
    n_chk++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL reset_estado got %0d want 0", db_estado); end
    n_chk++; if ({ativo, fim, venceu} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {ativo, fim, venceu}); end
    n_chk++; if ({db_rodada, db_jogada} !== 8'h00) begin n_fail++; $display("FAIL reset_counters got %h want 00", {db_rodada, db_jogada}); end
    // flags are ignored in INICIAL
    ganhou = 1; perdeu = 1;
    step(); step();
    ganhou = 0; perdeu = 0;
    n_chk++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL inicial_ignores_flags got %0d want 0", db_estado); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    do_reset();
    start_run();
    wait_for(0, 4'd2, 4'd2, 4'd0, 200, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL midrun_reach_round3 got timeout want press"); end
    step();
    reset = 1;
    step();
    reset = 0;
    n_chk++; if (botoes !== 4'b0000) begin n_fail++; $display("FAIL midrun_reset_botoes got %b want 0000", botoes); end
    n_chk++; if (db_estado !== 4'd0 || ativo !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_state got %0d/%b want 0/0", db_estado, ativo); end
    start_run();
    n_chk++; if (botoes !== 4'b0001 || db_rodada !== 4'd0) begin n_fail++; $display("FAIL midrun_restart got %b r%0d want 0001 r0", botoes, db_rodada); end
  endtask

  task automatic test_rounds_timing();
    int gaps;
    do_reset();
    iniciar = 1;
    step();
    iniciar = 0;
    n_chk++; if (db_estado !== 4'd1 || ativo !== 1'b1 || botoes !== 4'b0000) begin n_fail++; $display("FAIL prepara got est%0d ativo%b bot%b want 1/1/0000", db_estado, ativo, botoes); end
    step();
    // zero run after each play = SOLTA duration plus the PROXIMA cycle
    for (int r = 1; r <= 2; r++)
      for (int j = 0; j < r; j++) begin
        for (int c = 0; c < PRESS; c++) begin
          n_chk++; if (botoes !== rom_ref[j] || db_estado !== 4'd2) begin n_fail++; $display("FAIL timing_press r%0d j%0d c%0d got %b est%0d want %b est2", r, j, c, botoes, db_estado, rom_ref[j]); end
          step();
        end
        gaps = ((j == r - 1) ? RGAP : GAP) + 1;
        for (int c = 0; c < gaps; c++) begin
          n_chk++; if (botoes !== 4'b0000) begin n_fail++; $display("FAIL timing_gap r%0d j%0d c%0d got %b want 0000", r, j, c, botoes); end
          step();
        end
      end
    n_chk++; if (botoes !== 4'b0001 || db_rodada !== 4'd2) begin n_fail++; $display("FAIL timing_round3_start got %b r%0d want 0001 r2", botoes, db_rodada); end
  endtask

  task automatic test_full_run();
    int gaps, presses;
    logic [3:0] prev;
    do_reset();
    start_run();
    presses = 0;
    prev = 4'b0000;
    for (int r = 1; r <= 16; r++)
      for (int j = 0; j < r; j++) begin
        for (int c = 0; c < PRESS; c++) begin
          n_chk++; if (botoes !== rom_ref[j]) begin n_fail++; $display("FAIL full_press r%0d j%0d got %b want %b", r, j, botoes, rom_ref[j]); end
          if (botoes != 4'b0000 && prev == 4'b0000) presses++;
          prev = botoes;
          step();
        end
        gaps = ((j == r - 1) ? RGAP : GAP) + 1;
        for (int c = 0; c < gaps; c++) begin
          n_chk++; if (botoes !== 4'b0000) begin n_fail++; $display("FAIL full_gap r%0d j%0d got %b want 0000", r, j, botoes); end
          prev = botoes;
          step();
        end
      end
    n_chk++; if (presses != 136) begin n_fail++; $display("FAIL full_press_count got %0d want 136", presses); end
    n_chk++; if (db_estado !== 4'd7 || fim !== 1'b1 || venceu !== 1'b0) begin n_fail++; $display("FAIL full_timeout got est%0d fim%b venceu%b want 7/1/0", db_estado, fim, venceu); end
    n_chk++; if (db_rodada !== 4'd15 || botoes !== 4'b0000 || ativo !== 1'b0) begin n_fail++; $display("FAIL full_end got r%0d bot%b ativo%b want 15/0000/0", db_rodada, botoes, ativo); end
  endtask

  task automatic test_win();
    bit ok;
    do_reset();
    start_run();
    wait_for(0, 4'd3, 4'd3, 4'd0, 300, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL win_reach_round4 got timeout want solta"); end
    ganhou = 1;
    step();
    ganhou = 0;
    n_chk++; if (db_estado !== 4'd5 || fim !== 1'b1 || venceu !== 1'b1 || botoes !== 4'b0000) begin n_fail++; $display("FAIL win_state got est%0d fim%b venceu%b bot%b want 5/1/1/0000", db_estado, fim, venceu, botoes); end
    step(); step();
    n_chk++; if (db_estado !== 4'd5 || fim !== 1'b1) begin n_fail++; $display("FAIL win_hold got est%0d fim%b want 5/1", db_estado, fim); end
    iniciar = 1;
    step();
    iniciar = 0;
    n_chk++; if (db_estado !== 4'd1 || fim !== 1'b0 || venceu !== 1'b0) begin n_fail++; $display("FAIL win_restart got est%0d fim%b venceu%b want 1/0/0", db_estado, fim, venceu); end
  endtask

  task automatic test_error_injection();
    bit ok;
    do_reset();
    iniciar_e = 1;
    step();
    iniciar_e = 0;
    wait_for(1, 4'd2, 4'd2, 4'd1, 300, ok);
    n_chk++; if (!ok || botoes_e !== 4'b0010) begin n_fail++; $display("FAIL err_normal_play got ok%b %b want 1 0010", ok, botoes_e); end
    wait_for(1, 4'd2, 4'd2, 4'd2, 50, ok);
    n_chk++; if (!ok || botoes_e !== 4'b1000) begin n_fail++; $display("FAIL err_corrupt_play got ok%b %b want 1 1000", ok, botoes_e); end
    perdeu_e = 1;
    step();
    perdeu_e = 0;
    n_chk++; if (db_estado_e !== 4'd6 || fim_e !== 1'b1 || venceu_e !== 1'b0 || botoes_e !== 4'b0000) begin n_fail++; $display("FAIL err_perdeu got est%0d fim%b venceu%b bot%b want 6/1/0/0000", db_estado_e, fim_e, venceu_e, botoes_e); end
  endtask

  task automatic test_both_flags();
    bit ok;
    do_reset();
    start_run();
    step();
    n_chk++; if (botoes !== 4'b0001) begin n_fail++; $display("FAIL both_midpress got %b want 0001", botoes); end
    ganhou = 1; perdeu = 1;
    step();
    ganhou = 0; perdeu = 0;
    n_chk++; if (db_estado !== 4'd6 || venceu !== 1'b0 || botoes !== 4'b0000) begin n_fail++; $display("FAIL both_flags got est%0d venceu%b bot%b want 6/0/0000", db_estado, venceu, botoes); end
    ok = 1;
  endtask

  task automatic test_iniciar_held();
    int n_prep;
    bit stayed;
    do_reset();
    n_prep = 0;
    stayed = 1;
    iniciar = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (db_estado == 4'd1) n_prep++;
      if (ativo !== 1'b1) stayed = 0;
    end
    iniciar = 0;
    n_chk++; if (n_prep != 1) begin n_fail++; $display("FAIL held_prepara_count got %0d want 1", n_prep); end
    n_chk++; if (!stayed || db_estado !== 4'd4 || db_rodada !== 4'd0) begin n_fail++; $display("FAIL held_no_restart got ativo_ok%b est%0d r%0d want 1/4/0", stayed, db_estado, db_rodada); end
  endtask

  initial begin
    #1;
    test_reset();
    test_rounds_timing();
    test_reset_mid_run();
    test_full_run();
    test_win();
    test_error_injection();
    test_both_flags();
    test_iniciar_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
